reg_unlock_write_sequencer: RTL and testbench

//   Upstream front-end for the write-once data register. Host words arrive on a valid/ready stream.
//   A data word is forwarded only after the key sequence KEY1 then KEY2, with each step inside TIMEOUT cycles.
//   The forwarded word is issued as a single-cycle write pulse with registered data.
//   Bad keys, timeouts and writes to an already-locked register are blocked and reported.

---
 rtl/reg_unlock_write_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_reg_unlock_write_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_unlock_write_sequencer.sv
// -----------------------------------------------------------------------------
// reg_unlock_write_sequencer
//   Front-end for a write-once data register. Host words arrive on a
//   valid/ready stream. A data word is forwarded as a one-cycle write strobe
//   only after the key sequence KEY1, KEY2. Each step must arrive within
//   TIMEOUT idle cycles of the previous one. Bad keys, timeouts, writes to an
//   already-locked register and (optionally) parity failures are blocked.
//   They are reported through a sticky err / err_code pair.
//
// Optional feature macro: REG_WR_PARITY_EN
//   Adds input req_parity, the even parity over req_data. Every accepted word
//   is checked before any key or lock compare. A mismatch discards the word
//   and reports err_code 4. Without the macro the port is absent and code 4
//   never occurs.
//
// Ports
//   Clk          in   clock, rising edge
//   ip_resetn    in   asynchronous active-low reset
//   req_valid    in   host word valid
//   req_ready    out  sequencer can accept a word (low only in WRITE)
//   req_data     in   host word (key or payload), DW bits
//   req_parity   in   even parity of req_data (REG_WR_PARITY_EN only)
//   lock_status  in   1 = downstream register already written
//   clr_err      in   clear sticky error (a new error in the same cycle wins)
//   write        out  one-cycle write strobe to downstream register
//   wr_data      out  payload, valid with write and held until next write
//   armed        out  high while both keys have been seen
//   done         out  one-cycle pulse, coincident with write
//   err          out  sticky error flag
//   err_code     out  0 none, 1 bad key, 2 timeout, 3 locked, 4 parity
// -----------------------------------------------------------------------------
module reg_unlock_write_sequencer #(
    parameter int unsigned    DW      = 16,
    parameter logic [DW-1:0]  KEY1    = DW'(16'hA5A5),
    parameter logic [DW-1:0]  KEY2    = DW'(16'h5A5A),
    parameter int unsigned    TIMEOUT = 8
) (
    input  logic          Clk,
    input  logic          ip_resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_data,
`ifdef REG_WR_PARITY_EN
    input  logic          req_parity,
`endif
    input  logic          lock_status,
    input  logic          clr_err,
    output logic          write,
    output logic [DW-1:0] wr_data,
    output logic          armed,
    output logic          done,
    output logic          err,
    output logic [2:0]    err_code
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BAD_KEY = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_LOCKED  = 3'd3;
`ifdef REG_WR_PARITY_EN
    localparam logic [2:0] ERR_PARITY  = 3'd4;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_KEY1_OK = 2'd1,
        ST_ARMED   = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [TW-1:0]  timer_q;
    logic [TW-1:0]  timer_d;

    logic           accept_c;
    logic           expired_c;
    logic           parity_bad_c;
    logic           err_new_c;
    logic [2:0]     err_code_new_c;
    logic           fwd_c;

    logic           req_ready_d;
    logic           write_d;
    logic           done_d;
    logic           armed_d;
    logic [DW-1:0]  wr_data_d;
    logic           err_d;
    logic [2:0]     err_code_d;

    // Handshake and timer expiry; an accept in the expiry cycle wins.
    assign accept_c  = req_valid & req_ready;
    assign expired_c = (timer_q == '0) & ~accept_c;

`ifdef REG_WR_PARITY_EN
    // Even parity: the supplied bit must equal the XOR of the data bits.
    assign parity_bad_c = req_parity ^ (^req_data);
`else
    assign parity_bad_c = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            req_ready <= 1'b1;
            write     <= 1'b0;
            done      <= 1'b0;
            armed     <= 1'b0;
            wr_data   <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            req_ready <= req_ready_d;
            write     <= write_d;
            done      <= done_d;
            armed     <= armed_d;
            wr_data   <= wr_data_d;
            err       <= err_d;
            err_code  <= err_code_d;
        end
    end

    // Next-state, step timer and error detection.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        err_new_c      = 1'b0;
        err_code_new_c = ERR_NONE;
        fwd_c          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (accept_c) begin
                    if (parity_bad_c) begin
                        err_new_c      = 1'b1;
`ifdef REG_WR_PARITY_EN
                        err_code_new_c = ERR_PARITY;
`endif
                    end else if (req_data == KEY1) begin
                        state_d = ST_KEY1_OK;
                        timer_d = TW'(TIMEOUT);
                    end else begin
                        err_new_c      = 1'b1;
                        err_code_new_c = ERR_BAD_KEY;
                    end
                end
            end

            ST_KEY1_OK: begin
                if (accept_c) begin
                    if (parity_bad_c) begin
                        state_d        = ST_IDLE;
                        timer_d        = '0;
                        err_new_c      = 1'b1;
`ifdef REG_WR_PARITY_EN
                        err_code_new_c = ERR_PARITY;
`endif
                    end else if (req_data == KEY2) begin
                        state_d = ST_ARMED;
                        timer_d = TW'(TIMEOUT);
                    end else begin
                        state_d        = ST_IDLE;
                        timer_d        = '0;
                        err_new_c      = 1'b1;
                        err_code_new_c = ERR_BAD_KEY;
                    end
                end else if (expired_c) begin
                    state_d        = ST_IDLE;
                    err_new_c      = 1'b1;
                    err_code_new_c = ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_ARMED: begin
                if (accept_c) begin
                    timer_d = '0;
                    if (parity_bad_c) begin
                        state_d        = ST_IDLE;
                        err_new_c      = 1'b1;
`ifdef REG_WR_PARITY_EN
                        err_code_new_c = ERR_PARITY;
`endif
                    end else if (lock_status) begin
                        state_d        = ST_IDLE;
                        err_new_c      = 1'b1;
                        err_code_new_c = ERR_LOCKED;
                    end else begin
                        state_d = ST_WRITE;
                        fwd_c   = 1'b1;
                    end
                end else if (expired_c) begin
                    state_d        = ST_IDLE;
                    err_new_c      = 1'b1;
                    err_code_new_c = ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_WRITE: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        req_ready_d = (state_d != ST_WRITE);
        write_d     = (state_d == ST_WRITE);
        done_d      = (state_d == ST_WRITE);
        armed_d     = (state_d == ST_ARMED);
        wr_data_d   = wr_data;
        err_d       = err;
        err_code_d  = err_code;

        if (fwd_c) begin
            wr_data_d = req_data;
        end

        // A fresh error beats a simultaneous clear.
        if (err_new_c) begin
            err_d      = 1'b1;
            err_code_d = err_code_new_c;
        end else if (clr_err) begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end
    end

endmodule

// File: tb/tb_reg_unlock_write_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reg_unlock_write_sequencer
//   Directed scenarios followed by randomized traffic. Every cycle the DUT
//   outputs are compared with a behavioural model that tracks the unlock
//   progress and counts idle cycles since the last step.
// -----------------------------------------------------------------------------
module tb_reg_unlock_write_sequencer;

    localparam int unsigned    DW      = 16;
    localparam logic [DW-1:0]  KEY1    = 16'hA5A5;
    localparam logic [DW-1:0]  KEY2    = 16'h5A5A;
    localparam int             TIMEOUT = 8;

    logic          Clk = 1'b0;
    logic          ip_resetn;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_data;
    logic          req_parity;
    logic          lock_status;
    logic          clr_err;
    logic          write;
    logic [DW-1:0] wr_data;
    logic          armed;
    logic          done;
    logic          err;
    logic [2:0]    err_code;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 KEY1 seen, 2 armed, 3 write pulse this cycle.
    int            m_phase;
    int            m_idle;
    logic [DW-1:0] m_wdata;
    logic          m_err;
    logic [2:0]    m_code;

    reg_unlock_write_sequencer #(
        .DW      (DW),
        .KEY1    (KEY1),
        .KEY2    (KEY2),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk         (Clk),
        .ip_resetn   (ip_resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
`ifdef REG_WR_PARITY_EN
        .req_parity  (req_parity),
`endif
        .lock_status (lock_status),
        .clr_err     (clr_err),
        .write       (write),
        .wr_data     (wr_data),
        .armed       (armed),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        check_eq("req_ready", 32'(req_ready), 32'(m_phase != 3));
        check_eq("write",     32'(write),     32'(m_phase == 3));
        check_eq("done",      32'(done),      32'(m_phase == 3));
        check_eq("armed",     32'(armed),     32'(m_phase == 2));
        check_eq("wr_data",   32'(wr_data),   32'(m_wdata));
        check_eq("err",       32'(err),       32'(m_err));
        check_eq("err_code",  32'(err_code),  32'(m_code));
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_idle  = 0;
        m_wdata = '0;
        m_err   = 1'b0;
        m_code  = 3'd0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit       acc;
        bit       par_bad;
        bit       new_e;
        logic [2:0] c;
        acc     = req_valid && (m_phase != 3);
        new_e   = 0;
        c       = 3'd0;
`ifdef REG_WR_PARITY_EN
        par_bad = (req_parity != (^req_data));
`else
        par_bad = 0;
`endif
        if (m_phase == 3) begin
            m_phase = 0;
        end else if (acc && par_bad) begin
            m_phase = 0; new_e = 1; c = 3'd4;
        end else if (acc) begin
            case (m_phase)
                0: if (req_data == KEY1) begin m_phase = 1; m_idle = 0; end
                   else begin new_e = 1; c = 3'd1; end
                1: if (req_data == KEY2) begin m_phase = 2; m_idle = 0; end
                   else begin m_phase = 0; new_e = 1; c = 3'd1; end
                default: if (lock_status) begin m_phase = 0; new_e = 1; c = 3'd3; end
                         else begin m_phase = 3; m_wdata = req_data; end
            endcase
        end else if (m_phase == 1 || m_phase == 2) begin
            // TIMEOUT idle cycles are allowed; the next one expires.
            if (m_idle == TIMEOUT) begin
                m_phase = 0; new_e = 1; c = 3'd2;
            end else begin
                m_idle++;
            end
        end
        if (new_e) begin
            m_err = 1'b1; m_code = c;
        end else if (clr_err) begin
            m_err = 1'b0; m_code = 3'd0;
        end
    endtask

    // One clock: drive inputs, update model, sample after the edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic lock,
                       input logic clr, input logic bad_par);
        req_valid   = v;
        req_data    = d;
        req_parity  = (^d) ^ bad_par;
        lock_status = lock;
        clr_err     = clr;
        model_step();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        ip_resetn = 1'b0;
        req_valid = 1'b0;
        clr_err   = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge Clk);
        #1;
        ip_resetn = 1'b1;
    endtask

    initial begin
        ip_resetn   = 1'b1;
        req_valid   = 1'b0;
        req_data    = '0;
        req_parity  = 1'b0;
        lock_status = 1'b0;
        clr_err     = 1'b0;
        model_reset();
        #2;
        reset_dut();

        // Happy path, back to back.
        cyc(1'b1, KEY1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, KEY2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        check_eq("happy_write", 32'(write), 32'd1);
        check_eq("happy_data", 32'(wr_data), 32'h1234);
        check_eq("happy_err", 32'(err), 32'd0);
        cyc(1'b1, KEY1, 1'b0, 1'b0, 1'b0);   // ignored: not ready during WRITE
        check_eq("write_pulse_end", 32'(write), 32'd0);
        check_eq("wr_data_held", 32'(wr_data), 32'h1234);

        // Bad second key, then a good sequence with err still set.
        cyc(1'b1, KEY1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h5A5B, 1'b0, 1'b0, 1'b0);
        check_eq("badkey_code", 32'(err_code), 32'd1);
        cyc(1'b1, KEY1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, KEY2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0);
        check_eq("badkey_then_write", 32'(wr_data), 32'h00FF);
        check_eq("err_sticky", 32'(err), 32'd1);
        idle(1);

        // Timeout after nine idle cycles.
        cyc(1'b1, KEY1, 1'b0, 1'b0, 1'b0);
        idle(TIMEOUT + 1);
        check_eq("timeout_code", 32'(err_code), 32'd2);
        check_eq("timeout_armed", 32'(armed), 32'd0);

        // clr_err alone.
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check_eq("clr_err", 32'(err), 32'd0);

        // Accept in the very cycle the timer hits zero.
        cyc(1'b1, KEY1, 1'b0, 1'b0, 1'b0);
        idle(TIMEOUT);
        cyc(1'b1, KEY2, 1'b0, 1'b0, 1'b0);
        check_eq("late_key2_armed", 32'(armed), 32'd1);
        check_eq("late_key2_noerr", 32'(err), 32'd0);

        // Locked downstream register.
        cyc(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        check_eq("locked_code", 32'(err_code), 32'd3);
        check_eq("locked_nowrite", 32'(write), 32'd0);

        // clr_err coincident with a bad key.
        cyc(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0);
        check_eq("clr_vs_new_err", 32'(err_code), 32'd1);

        // Reset while armed; a payload afterwards is just a bad key.
        cyc(1'b1, KEY1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, KEY2, 1'b0, 1'b0, 1'b0);
        reset_dut();
        check_eq("rst_armed", 32'(armed), 32'd0);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        check_eq("rst_needs_key", 32'(write), 32'd0);

`ifdef REG_WR_PARITY_EN
        cyc(1'b1, KEY1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, KEY2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        check_eq("parity_code", 32'(err_code), 32'd4);
        check_eq("parity_nowrite", 32'(write), 32'd0);
`endif

        // Randomized traffic biased toward the key sequence.
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            logic [DW-1:0] d;
            if (i % 250 == 0) idle(TIMEOUT + 2);
            if ($urandom_range(0, 599) == 0) reset_dut();
            r = $urandom_range(0, 9);
            if (r < 4)      d = KEY1;
            else if (r < 7) d = KEY2;
            else            d = DW'($urandom);
            cyc(($urandom_range(0, 3) != 0),
                d,
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0),
`ifdef REG_WR_PARITY_EN
                ($urandom_range(0, 19) == 0)
`else
                1'b0
`endif
            );
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
